// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one 16-bit SRAM between the fetch and data ports.
// Round-robin grant, 32-bit accesses split into two halfword cycles.
module sram_port_arbiter #(
   parameter int ADDR_W = 20
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [31:0]       i_if_addr,
   output logic              o_if_ready,
   output logic [31:0]       o_if_rdata,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [2:0]        i_d_funct3,
   input  logic [31:0]       i_d_addr,
   input  logic [31:0]       i_d_wdata,
   output logic              o_d_ready,
   output logic [31:0]       o_d_rdata,
   output logic              o_d_err,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [15:0]       o_sram_dq,
   output logic              o_sram_dq_oe,
   input  logic [15:0]       i_sram_dq,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n,
   output logic              o_sram_ub_n,
   output logic              o_sram_lb_n
);
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt_q, gnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W:0]   addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [15:0]       hi_q, hi_d, lo_q, lo_d;
   logic              if_ready_q, if_ready_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic              d_ready_q, d_ready_d;
   logic [31:0]       d_rdata_q, d_rdata_d;
   logic              d_err_q, d_err_d;
   logic [ADDR_W-1:0] sa_q, sa_d;
   logic [15:0]       dq_q, dq_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d;

   logic              start, pick, is_byte, is_half, is_word;
   logic              bad_f3, misal, bad, acc;
   logic [7:0]        ld_byte;
   logic [31:0]       ld_val;
   logic              unused_ok;

   // pick = 1 grants data; on a tie the port not granted last wins
   assign start   = (state_q == IDLE) && (i_if_req || i_d_req);
   assign pick    = i_d_req && (!i_if_req || !last_q);
   assign is_byte = gnt_d && (f3_d[1:0] == 2'b00);
   assign is_half = gnt_d && (f3_d[1:0] == 2'b01);
   assign is_word = !is_byte && !is_half;
   assign bad_f3  = we_d ? (f3_d[2] || (f3_d[1:0] == 2'b11))
                         : ((f3_d == 3'b011) || (f3_d[2:1] == 2'b11));
   assign misal   = (is_half && addr_d[0]) ||
                    (gnt_d && (f3_d[1:0] == 2'b10) && (addr_d[1:0] != 2'b00));
   assign bad     = gnt_d && (bad_f3 || misal);
   assign ld_byte = addr_q[0] ? hi_q[7:0] : hi_q[15:8];
   assign unused_ok = ^{i_if_addr[31:ADDR_W+1], i_d_addr[31:ADDR_W+1]};

   // latch the granted transaction's fields
   always_comb begin
      gnt_d   = gnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (start) begin
         gnt_d = pick;
         if (pick) begin
            we_d    = i_d_we;
            f3_d    = i_d_funct3;
            addr_d  = i_d_addr[ADDR_W:0];
            wdata_d = i_d_wdata;
         end else begin
            we_d    = 1'b0;
            f3_d    = 3'b010;
            addr_d  = i_if_addr[ADDR_W:0];
            wdata_d = '0;
         end
      end
   end

   // load extension of the captured halves
   always_comb begin
      ld_val = {hi_q, lo_q};
      case (f3_q)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_val = {24'h0, ld_byte};
         3'b001:  ld_val = {{16{hi_q[15]}}, hi_q};
         3'b101:  ld_val = {16'h0, hi_q};
         default: ld_val = {hi_q, lo_q};
      endcase
   end

   // sequencing, read capture and response
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      err_d      = err_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      if_ready_d = 1'b0;
      d_ready_d  = 1'b0;
      d_err_d    = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACC0;
               err_d   = bad;
               last_d  = pick;
            end
         end
         ACC0: begin
            if (!we_q && !err_q) hi_d = i_sram_dq;
            state_d = (is_word && !err_q) ? ACC1 : RESP;
         end
         ACC1: begin
            if (!we_q) lo_d = i_sram_dq;
            state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
            if (gnt_q) begin
               d_ready_d = 1'b1;
               d_err_d   = err_q;
               if (!err_q && !we_q) d_rdata_d = ld_val;
            end else begin
               if_ready_d = 1'b1;
               if_rdata_d = {hi_q, lo_q};
            end
         end
      endcase
   end

   // SRAM pins for the next cycle, from next state and latched fields
   always_comb begin
      acc     = ((state_d == ACC0) || (state_d == ACC1)) && !err_d;
      ce_n_d  = !acc;
      oe_n_d  = !(acc && !we_d);
      we_n_d  = !(acc && we_d);
      dq_oe_d = acc && we_d;
      ub_n_d  = 1'b1;
      lb_n_d  = 1'b1;
      dq_d    = '0;
      sa_d    = sa_q;
      if (acc) begin
         ub_n_d = is_byte && addr_d[0];
         lb_n_d = is_byte && !addr_d[0];
         if (is_word) sa_d = {addr_d[ADDR_W:2], state_d == ACC1};
         else         sa_d = addr_d[ADDR_W:1];
         if (we_d) begin
            if (is_byte)                          dq_d = {2{wdata_d[7:0]}};
            else if (is_word && state_d == ACC0) dq_d = wdata_d[31:16];
            else                                  dq_d = wdata_d[15:0];
         end
      end
   end

   // state and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b0;
         gnt_q      <= 1'b0;
         we_q       <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         if_ready_q <= 1'b0;
         if_rdata_q <= '0;
         d_ready_q  <= 1'b0;
         d_rdata_q  <= '0;
         d_err_q    <= 1'b0;
         sa_q       <= '0;
         dq_q       <= '0;
         dq_oe_q    <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         ub_n_q     <= 1'b1;
         lb_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         if_ready_q <= if_ready_d;
         if_rdata_q <= if_rdata_d;
         d_ready_q  <= d_ready_d;
         d_rdata_q  <= d_rdata_d;
         d_err_q    <= d_err_d;
         sa_q       <= sa_d;
         dq_q       <= dq_d;
         dq_oe_q    <= dq_oe_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         ub_n_q     <= ub_n_d;
         lb_n_q     <= lb_n_d;
      end
   end

   assign o_if_ready   = if_ready_q;
   assign o_if_rdata   = if_rdata_q;
   assign o_d_ready    = d_ready_q;
   assign o_d_rdata    = d_rdata_q;
   assign o_d_err      = d_err_q;
   assign o_sram_addr  = sa_q;
   assign o_sram_dq    = dq_q;
   assign o_sram_dq_oe = dq_oe_q;
   assign o_sram_ce_n  = ce_n_q;
   assign o_sram_oe_n  = oe_n_q;
   assign o_sram_we_n  = we_n_q;
   assign o_sram_ub_n  = ub_n_q;
   assign o_sram_lb_n  = lb_n_q;
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single 16-bit external SRAM between the CPU instruction-fetch port and the data-memory (load/store) port. It arbitrates between the two requesters and latches the granted transaction. It then splits 32-bit accesses into two sequential 16-bit SRAM cycles, drives the SRAM control strobes and byte lanes, and returns sign- or zero-extended read data with a one-cycle ready pulse. It sits between the pipeline's IF/MEM stages and the SRAM pins; its `ready` outputs are the stall release for both stages.

## Interface
- `ADDR_W`, default 20: SRAM halfword-address width. CPU byte address bits `[ADDR_W:0]` are used; higher bits are ignored.
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_if_req`  in  1  fetch request; 32-bit word read.
- `i_if_addr`  in  32  fetch byte address; bits `[1:0]` are ignored.
- `o_if_ready`  out  1  one-cycle pulse: fetch complete, `o_if_rdata` valid.
- `o_if_rdata`  out  32  fetched word; held until the next fetch completes.
- `i_d_req`  in  1  data request.
- `i_d_we`  in  1  1 = store, 0 = load.
- `i_d_funct3`  in  3  RV32I load/store funct3.
- `i_d_addr`  in  32  data byte address.
- `i_d_wdata`  in  32  store data; the byte or half is taken from the low bits.
- `o_d_ready`  out  1  one-cycle pulse: data access complete.
- `o_d_rdata`  out  32  load result; held until the next data load completes.
- `o_d_err`  out  1  pulse coincident with `o_d_ready` for an illegal funct3 or a misaligned address.
- `o_sram_addr`  out  `ADDR_W`  SRAM halfword address.
- `o_sram_dq`  out  16  SRAM write data.
- `o_sram_dq_oe`  out  1  tristate enable for `o_sram_dq`.
- `i_sram_dq`  in  16  SRAM read data.
- `o_sram_ce_n`, `o_sram_oe_n`, `o_sram_we_n`, `o_sram_ub_n`, `o_sram_lb_n`  out  1 each  active-low SRAM strobes.

## Operation
- FSM states: `IDLE`, `ACC0`, `ACC1`, `RESP`.
- **Request sampling:** requests are sampled only in `IDLE`. On grant, the address, funct3, we and wdata are latched, so requester inputs may change after the grant.
- **Arbitration:**
  - Single request: that requester is granted.
  - Both requests: the requester not granted last is granted (round-robin).
  - The `last` register resets to fetch, so data wins the first tie.
- **Access cycles:**
  - `ACC0` always occurs.
  - `ACC1` occurs only for word accesses: fetch, LW, SW.
  - Byte and half accesses go `ACC0` to `RESP`.
- **SRAM addresses:**
  - Word: `ACC0` uses `{A[ADDR_W:2],0}` and returns the high half, data `[31:16]`. `ACC1` uses `{A[ADDR_W:2],1}` and returns the low half, data `[15:0]`.
  - Half and byte: `A[ADDR_W:1]`.
- **Byte lanes:**
  - Word and half: both lanes enabled.
  - Byte: `A[0]=0` selects the upper lane (`ub_n=0`, `lb_n=1`, data `[15:8]`). `A[0]=1` selects the lower lane (`ub_n=1`, `lb_n=0`, data `[7:0]`).
- **Load extension:** LB and LH sign-extend; LBU and LHU zero-extend; LW is the full word.
- **Store data:**
  - SB drives `{wdata[7:0], wdata[7:0]}`, with only the selected lane enabled.
  - SH drives `wdata[15:0]`.
  - SW drives `wdata[31:16]` in `ACC0` and `wdata[15:0]` in `ACC1`.
- **Errors:**
  - Illegal funct3: load 011/110/111, or store with `funct3 >= 011`.
  - Misalignment: half access with `A[0]=1`, or word access with `A[1:0]!=0`.
  - On error: `ACC0` carries no strobes (all high), go to `RESP`, then `o_d_ready=1`, `o_d_err=1`, `o_d_rdata` unchanged, and the SRAM is unmodified.
- **Strobes:**
  - In `ACC0`/`ACC1` reads: `ce_n=0`, `oe_n=0`, `we_n=1`, `dq_oe=0`.
  - In `ACC0`/`ACC1` writes: `ce_n=0`, `oe_n=1`, `we_n=0`, `dq_oe=1`.
  - In every other state: all strobes 1 and `dq_oe=0`.
  - All SRAM outputs decode from registered state and latched fields only; there is no combinational path from `i_*` requests.
- **Read capture:** `i_sram_dq` is captured at the end of each read `ACC` cycle.
- **Response:** `RESP` pulses the granted port's `ready` and returns to `IDLE`.

## Timing
- Request seen high at edge k (FSM in `IDLE`):
  - `ACC0` spans k..k+1.
  - Word: `ACC1` spans k+1..k+2, and `ready` is high in the cycle after edge k+3.
  - Byte/half: `ready` is high in the cycle after edge k+2.
- In other words: word latency is 3 cycles to `ready`, byte/half is 2 cycles, and an errored access is 2 cycles.
- The minimum request-to-request period is 4 cycles for words (`IDLE` is revisited for one cycle).
- A `req` still high in the `IDLE` cycle after `ready` is a new transaction. Requesters must drop `req` on `ready` unless issuing another.
- `rdata` updates in the same cycle `ready` rises.
- A requester not granted keeps `req` high and is served immediately after the current transaction.
- **Reset values:** state `IDLE`, all SRAM strobes 1, `dq_oe=0`, `o_sram_addr=0`, `o_sram_dq=0`, both `ready` outputs 0, both `rdata` outputs 0, `o_d_err=0`, `last`=fetch.
- **Reset mid-transaction:** the transaction is aborted and no `ready` is issued. Strobes go high on the edge where reset is sampled. A word store interrupted after `ACC0` leaves only the high half written; this is acceptable.

## Test plan
- **Fetch word:** SRAM hw[0x100]=0x1234, hw[0x101]=0xABCD; fetch `A=0x200` -> `o_if_rdata=0x1234ABCD`, `ready` 3 cycles after the request edge, `ub_n`/`lb_n` both 0.
- **Byte and half loads:** hw[0x10]=0x80F1.
  - LB `A=0x20` -> 0xFFFFFF80.
  - LBU `A=0x21` -> 0x000000F1.
  - LH `A=0x20` -> 0xFFFF80F1.
  - LHU -> 0x000080F1.
  - Each has 2-cycle latency.
- **Stores:**
  - SB `wdata=0x5A`, `A=0x21`, onto 0x80F1 -> hw=0x805A, with `ub_n=1`, `lb_n=0`, `we_n=0` for 1 cycle.
  - SW 0xDEADBEEF at `A=0x40` -> hw[0x20]=0xDEAD, hw[0x21]=0xBEEF.
- **Contention:** both requests held from the first post-reset cycle -> data granted first, then fetch. Three back-to-back conflicts alternate D, F, D. Neither port ever starves.
- **Errors:** LW `A=0x42` and load funct3=3 -> each gets `o_d_ready`+`o_d_err` 2 cycles after the request, no strobe low, SRAM unchanged, `o_d_rdata` holds its prior value.
- **Reset mid-transaction:** assert `i_rst` during `ACC1` of an LW -> next cycle all strobes 1, no `ready` pulse. After release, a fresh LW completes normally.
